// File: rtl/eye_lock_ctrl.sv
// eye_lock_ctrl: frame-synchronous lock controller for the eye overlay.
// Collects detector/tracker eye boxes during a frame, validates their
// geometry, and at each frame_start runs the SEARCH/ACQUIRE/LOCKED/COAST
// machine. Display boxes and eye_lock change only at frame boundaries.
// Optional build macro EYE_LOCK_STATS_EN adds the 16-bit lock_loss_cnt output.
module eye_lock_ctrl #(
  parameter int COORD_W     = 11,
  parameter int H_ACT       = 800,
  parameter int V_ACT       = 480,
  parameter int LOCK_FRAMES = 3,
  parameter int LOST_FRAMES = 8
) (
  input  logic                 lcd_clk,
  input  logic                 sys_rst_n,
  input  logic                 frame_start,
  input  logic                 det_valid,
  input  logic [4*COORD_W-1:0] det_eye1,
  input  logic [4*COORD_W-1:0] det_eye2,
  input  logic                 trk_valid,
  input  logic [4*COORD_W-1:0] trk_eye1,
  input  logic [4*COORD_W-1:0] trk_eye2,
  output logic [4*COORD_W-1:0] disp_eye1,
  output logic [4*COORD_W-1:0] disp_eye2,
  output logic [10:0]          eye_lock,
  output logic [1:0]           lock_state
`ifdef EYE_LOCK_STATS_EN
  ,
  output logic [15:0]          lock_loss_cnt
`endif
);

  localparam int BOX_W  = 4 * COORD_W;
  localparam int MAX_FR = (LOCK_FRAMES > LOST_FRAMES) ? LOCK_FRAMES : LOST_FRAMES;
  localparam int CNT_W  = $clog2(MAX_FR) + 1;

  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   LOCK_CNT = CNT_W'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0]   LOST_CNT = CNT_W'(LOST_FRAMES);
  localparam logic [COORD_W:0]   H_LIM    = (COORD_W+1)'(H_ACT);
  localparam logic [COORD_W:0]   V_LIM    = (COORD_W+1)'(V_ACT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    COAST   = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   acq_cnt_reg, acq_cnt_next;
  logic [CNT_W-1:0]   miss_cnt_reg, miss_cnt_next;
  logic [CNT_W-1:0]   acq_inc, miss_inc;
  logic [BOX_W-1:0]   disp1_reg, disp1_next;
  logic [BOX_W-1:0]   disp2_reg, disp2_next;
  logic [10:0]        eye_lock_reg;
  logic [BOX_W-1:0]   pend_det1_reg, pend_det2_reg;
  logic [BOX_W-1:0]   pend_trk1_reg, pend_trk2_reg;
  logic               det_seen_reg, trk_seen_reg;

  // Geometry check on all four incoming boxes: det1, det2, trk1, trk2.
  logic [BOX_W-1:0]   box_in [4];
  logic [3:0]         box_ok;

  assign box_in[0] = det_eye1;
  assign box_in[1] = det_eye2;
  assign box_in[2] = trk_eye1;
  assign box_in[3] = trk_eye2;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_geom
      logic [COORD_W-1:0] up, down, left, right;
      assign up    = box_in[gi][4*COORD_W-1 -: COORD_W];
      assign down  = box_in[gi][3*COORD_W-1 -: COORD_W];
      assign left  = box_in[gi][2*COORD_W-1 -: COORD_W];
      assign right = box_in[gi][COORD_W-1:0];
      assign box_ok[gi] = (up < down) && (left < right) &&
                          ({1'b0, right} < H_LIM) && ({1'b0, down} < V_LIM);
    end
  endgenerate

  // A result is usable only if both eyes pass and the machine is in the
  // mode that consumes it (detection while searching, tracking while locked).
  logic det_take, trk_take;
  assign det_take = det_valid && box_ok[0] && box_ok[1] && !state_reg[1];
  assign trk_take = trk_valid && box_ok[2] && box_ok[3] &&  state_reg[1];

  // Results arriving on the frame_start cycle still belong to the ending
  // frame, so evaluation looks through the pending registers to them.
  logic             det_seen_eff, trk_seen_eff;
  logic [BOX_W-1:0] det1_eff, det2_eff, trk1_eff, trk2_eff;
  assign det_seen_eff = det_seen_reg || det_take;
  assign trk_seen_eff = trk_seen_reg || trk_take;
  assign det1_eff     = det_take ? det_eye1 : pend_det1_reg;
  assign det2_eff     = det_take ? det_eye2 : pend_det2_reg;
  assign trk1_eff     = trk_take ? trk_eye1 : pend_trk1_reg;
  assign trk2_eff     = trk_take ? trk_eye2 : pend_trk2_reg;

  // Frame-boundary evaluation: next state, counters and display boxes.
  always_comb begin
    state_next    = state_reg;
    acq_cnt_next  = acq_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    disp1_next    = disp1_reg;
    disp2_next    = disp2_reg;
    acq_inc       = acq_cnt_reg + CNT_ONE;
    miss_inc      = miss_cnt_reg + CNT_ONE;
    if (frame_start) begin
      unique case (state_reg)
        SEARCH: begin
          if (det_seen_eff) begin
            disp1_next = det1_eff;
            disp2_next = det2_eff;
            if (LOCK_CNT == CNT_ONE) begin
              state_next   = LOCKED;
              acq_cnt_next = '0;
            end else begin
              state_next   = ACQUIRE;
              acq_cnt_next = CNT_ONE;
            end
          end else begin
            disp1_next = '0;
            disp2_next = '0;
          end
        end
        ACQUIRE: begin
          if (det_seen_eff) begin
            disp1_next = det1_eff;
            disp2_next = det2_eff;
            if (acq_inc == LOCK_CNT) begin
              state_next   = LOCKED;
              acq_cnt_next = '0;
            end else begin
              acq_cnt_next = acq_inc;
            end
          end else begin
            state_next   = SEARCH;
            acq_cnt_next = '0;
            disp1_next   = '0;
            disp2_next   = '0;
          end
        end
        LOCKED: begin
          if (trk_seen_eff) begin
            disp1_next = trk1_eff;
            disp2_next = trk2_eff;
          end else if (LOST_CNT == CNT_ONE) begin
            state_next = SEARCH;
            disp1_next = '0;
            disp2_next = '0;
          end else begin
            state_next    = COAST;
            miss_cnt_next = CNT_ONE;
          end
        end
        COAST: begin
          if (trk_seen_eff) begin
            state_next    = LOCKED;
            miss_cnt_next = '0;
            disp1_next    = trk1_eff;
            disp2_next    = trk2_eff;
          end else if (miss_inc == LOST_CNT) begin
            state_next    = SEARCH;
            miss_cnt_next = '0;
            disp1_next    = '0;
            disp2_next    = '0;
          end else begin
            miss_cnt_next = miss_inc;
          end
        end
        default: begin
          state_next = SEARCH;
        end
      endcase
    end
  end

  // State, counters and published outputs update together.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= SEARCH;
      acq_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
      disp1_reg    <= '0;
      disp2_reg    <= '0;
      eye_lock_reg <= '0;
    end else begin
      state_reg    <= state_next;
      acq_cnt_reg  <= acq_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
      disp1_reg    <= disp1_next;
      disp2_reg    <= disp2_next;
      eye_lock_reg <= {11{state_next[1]}};
    end
  end

  // Pending result capture; seen flags are consumed at each frame boundary.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_det1_reg <= '0;
      pend_det2_reg <= '0;
      pend_trk1_reg <= '0;
      pend_trk2_reg <= '0;
      det_seen_reg  <= 1'b0;
      trk_seen_reg  <= 1'b0;
    end else begin
      if (det_take) begin
        pend_det1_reg <= det_eye1;
        pend_det2_reg <= det_eye2;
      end
      if (trk_take) begin
        pend_trk1_reg <= trk_eye1;
        pend_trk2_reg <= trk_eye2;
      end
      det_seen_reg <= frame_start ? 1'b0 : (det_seen_reg || det_take);
      trk_seen_reg <= frame_start ? 1'b0 : (trk_seen_reg || trk_take);
    end
  end

  assign disp_eye1  = disp1_reg;
  assign disp_eye2  = disp2_reg;
  assign eye_lock   = eye_lock_reg;
  assign lock_state = state_reg;

`ifdef EYE_LOCK_STATS_EN
  logic [15:0] loss_cnt_reg;
  logic        loss_event;
  assign loss_event = frame_start && state_reg[1] && (state_next == SEARCH);

  // Saturating count of lock losses (tracking mode falling back to SEARCH).
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      loss_cnt_reg <= '0;
    end else if (loss_event && (loss_cnt_reg != 16'hFFFF)) begin
      loss_cnt_reg <= loss_cnt_reg + 16'd1;
    end
  end

  assign lock_loss_cnt = loss_cnt_reg;
`endif

endmodule

// File: tb/tb_eye_lock_ctrl.sv
// tb_eye_lock_ctrl: directed scenarios followed by randomized frames, all
// checked against a frame-level reference model of the lock controller.
// Build with EYE_LOCK_STATS_EN defined to also check lock_loss_cnt.
module tb_eye_lock_ctrl;

  logic        lcd_clk;
  logic        sys_rst_n;
  logic        frame_start;
  logic        det_valid;
  logic [43:0] det_eye1, det_eye2;
  logic        trk_valid;
  logic [43:0] trk_eye1, trk_eye2;
  logic [43:0] disp_eye1, disp_eye2;
  logic [10:0] eye_lock;
  logic [1:0]  lock_state;
`ifdef EYE_LOCK_STATS_EN
  logic [15:0] lock_loss_cnt;
`endif

  eye_lock_ctrl dut (
    .lcd_clk     (lcd_clk),
    .sys_rst_n   (sys_rst_n),
    .frame_start (frame_start),
    .det_valid   (det_valid),
    .det_eye1    (det_eye1),
    .det_eye2    (det_eye2),
    .trk_valid   (trk_valid),
    .trk_eye1    (trk_eye1),
    .trk_eye2    (trk_eye2),
    .disp_eye1   (disp_eye1),
    .disp_eye2   (disp_eye2),
    .eye_lock    (eye_lock),
    .lock_state  (lock_state)
`ifdef EYE_LOCK_STATS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  initial lcd_clk = 1'b0;
  always #5 lcd_clk = ~lcd_clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int frame_no = 0;

  // Reference model: mode 0..3 as plain integers, frame counters as ints.
  int          m_state, m_acq, m_miss, m_loss;
  logic [43:0] m_disp1, m_disp2;
  logic [43:0] m_pd1, m_pd2, m_pt1, m_pt2;
  bit          m_dseen, m_tseen;

  localparam int LOCK_N = 3;
  localparam int LOST_N = 8;
  localparam logic [43:0] Z = 44'd0;

  function automatic logic [43:0] mk(input int u, input int d, input int l, input int r);
    return {u[10:0], d[10:0], l[10:0], r[10:0]};
  endfunction

  function automatic bit geom_ok(input logic [43:0] b);
    int u, d, l, r;
    u = int'(b[43:33]);
    d = int'(b[32:22]);
    l = int'(b[21:11]);
    r = int'(b[10:0]);
    return (u < d) && (l < r) && (r < 800) && (d < 480);
  endfunction

  function automatic logic [43:0] rand_box(input bit good);
    int u, d, l, r;
    u = $urandom_range(0, 400);
    d = u + 1 + $urandom_range(0, 78);
    l = $urandom_range(0, 700);
    r = l + 1 + $urandom_range(0, 98);
    if (!good) begin
      case ($urandom_range(0, 3))
        0: d = u - $urandom_range(0, u);
        1: r = l - $urandom_range(0, l);
        2: r = $urandom_range(800, 2047);
        default: d = $urandom_range(480, 2047);
      endcase
    end
    return mk(u, d, l, r);
  endfunction

  task automatic model_reset();
    m_state = 0; m_acq = 0; m_miss = 0; m_loss = 0;
    m_disp1 = Z; m_disp2 = Z;
    m_pd1 = Z; m_pd2 = Z; m_pt1 = Z; m_pt2 = Z;
    m_dseen = 0; m_tseen = 0;
  endtask

  // One clock of the model: capture this cycle's results, then judge the frame.
  task automatic model_step(input bit fs, input bit dv, input logic [43:0] d1, d2,
                            input bit tv, input logic [43:0] t1, t2);
    bool_capture: begin
      if (dv && geom_ok(d1) && geom_ok(d2) && m_state < 2) begin
        m_pd1 = d1; m_pd2 = d2; m_dseen = 1;
      end
      if (tv && geom_ok(t1) && geom_ok(t2) && m_state >= 2) begin
        m_pt1 = t1; m_pt2 = t2; m_tseen = 1;
      end
    end
    if (fs) begin
      if (m_state < 2) begin
        if (m_dseen) begin
          m_acq   = (m_state == 0) ? 1 : m_acq + 1;
          m_disp1 = m_pd1; m_disp2 = m_pd2;
          if (m_acq >= LOCK_N) begin m_state = 2; m_acq = 0; end
          else m_state = 1;
        end else begin
          m_state = 0; m_acq = 0; m_disp1 = Z; m_disp2 = Z;
        end
      end else begin
        if (m_tseen) begin
          m_state = 2; m_miss = 0; m_disp1 = m_pt1; m_disp2 = m_pt2;
        end else begin
          m_miss = m_miss + 1;
          if (m_miss >= LOST_N) begin
            m_state = 0; m_miss = 0; m_disp1 = Z; m_disp2 = Z;
            if (m_loss < 65535) m_loss = m_loss + 1;
          end else begin
            m_state = 3;
          end
        end
      end
      m_dseen = 0; m_tseen = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string pfx);
    chk({pfx, "_state"}, 64'(lock_state), 64'(m_state));
    chk({pfx, "_eye_lock"}, 64'(eye_lock), (m_state >= 2) ? 64'h7FF : 64'h0);
    chk({pfx, "_disp1"}, 64'(disp_eye1), 64'(m_disp1));
    chk({pfx, "_disp2"}, 64'(disp_eye2), 64'(m_disp2));
`ifdef EYE_LOCK_STATS_EN
    chk({pfx, "_loss_cnt"}, 64'(lock_loss_cnt), 64'(m_loss));
`endif
  endtask

  task automatic step(input bit fs, input bit dv, input logic [43:0] d1, d2,
                      input bit tv, input logic [43:0] t1, t2);
    frame_start = fs; det_valid = dv; det_eye1 = d1; det_eye2 = d2;
    trk_valid = tv; trk_eye1 = t1; trk_eye2 = t2;
    model_step(fs, dv, d1, d2, tv, t1, t2);
    @(posedge lcd_clk); #1;
    frame_start = 0; det_valid = 0; trk_valid = 0;
    compare_all("cyc");
    if (fs) begin
      frame_no++;
      $display("frame %0d: state=%0d eye_lock=%h disp1=%h disp2=%h",
               frame_no, lock_state, eye_lock, disp_eye1, disp_eye2);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, Z, Z, 0, Z, Z);
  endtask

  // One frame: optional results mid-frame, then the boundary pulse.
  task automatic frame(input bit dv, input logic [43:0] d1, d2,
                       input bit tv, input logic [43:0] t1, t2);
    step(0, dv, d1, d2, tv, t1, t2);
    idle(1);
    step(1, 0, Z, Z, 0, Z, Z);
  endtask

  task automatic do_reset();
    sys_rst_n = 0;
    frame_start = 0; det_valid = 0; trk_valid = 0;
    model_reset();
    #1;
    compare_all("rst");
    @(posedge lcd_clk); #1;
    sys_rst_n = 1;
  endtask

  logic [43:0] e1, e2, tk1, tk2, tb1, bad1, bad2;
  int exp_acq [3] = '{1, 1, 2};

  initial begin
    e1   = mk(100, 120, 200, 260);
    e2   = mk(100, 120, 400, 460);
    tk1  = mk(90, 110, 210, 250);
    tk2  = mk(95, 115, 410, 450);
    tb1  = mk(50, 70, 60, 90);
    bad1 = mk(130, 120, 200, 260);
    bad2 = mk(100, 120, 200, 800);
    frame_start = 0; det_valid = 0; trk_valid = 0;
    det_eye1 = Z; det_eye2 = Z; trk_eye1 = Z; trk_eye2 = Z;
    sys_rst_n = 0;
    model_reset();
    @(posedge lcd_clk); #1;
    compare_all("por");
    chk("por_state_const", 64'(lock_state), 64'd0);
    sys_rst_n = 1;
    idle(2);

    // Mid-frame reset discards a pending valid detection.
    step(0, 1, e1, e2, 0, Z, Z);
    idle(1);
    do_reset();
    step(1, 0, Z, Z, 0, Z, Z);
    chk("mfrst_state", 64'(lock_state), 64'd0);
    chk("mfrst_disp1", 64'(disp_eye1), 64'd0);
    chk("mfrst_lock", 64'(eye_lock), 64'd0);

    // Three detection frames lead to lock.
    for (int f = 0; f < 3; f++) begin
      frame(1, e1, e2, 0, Z, Z);
      chk("acq_state", 64'(lock_state), 64'(exp_acq[f]));
      chk("acq_disp1", 64'(disp_eye1), 64'(e1));
    end
    chk("acq_lock", 64'(eye_lock), 64'h7FF);

    // Two tracked frames, then eight missing frames.
    for (int f = 0; f < 2; f++) begin
      frame(0, Z, Z, 1, tk1, tk2);
      chk("trk_state", 64'(lock_state), 64'd2);
      chk("trk_disp2", 64'(disp_eye2), 64'(tk2));
    end
    for (int f = 0; f < 8; f++) begin
      frame(0, Z, Z, 0, Z, Z);
      chk("lost_state", 64'(lock_state), (f < 7) ? 64'd3 : 64'd0);
      chk("lost_disp1", 64'(disp_eye1), (f < 7) ? 64'(tk1) : 64'd0);
    end
`ifdef EYE_LOCK_STATS_EN
    chk("lost_loss_cnt", 64'(lock_loss_cnt), 64'd1);
`endif

    // Malformed detections are dropped; ACQUIRE falls back to SEARCH.
    frame(1, e1, e2, 0, Z, Z);
    chk("bad_pre", 64'(lock_state), 64'd1);
    frame(1, bad1, e2, 0, Z, Z);
    chk("bad_updown", 64'(lock_state), 64'd0);
    frame(1, e1, e2, 0, Z, Z);
    frame(1, e1, bad2, 0, Z, Z);
    chk("bad_right", 64'(lock_state), 64'd0);
    chk("bad_disp", 64'(disp_eye1), 64'd0);

    // Detection coincident with frame_start counts for the ending frame.
    frame(1, e1, e2, 0, Z, Z);
    step(1, 1, e2, e1, 0, Z, Z);
    chk("coinc_state1", 64'(lock_state), 64'd1);
    chk("coinc_disp1", 64'(disp_eye1), 64'(e2));
    idle(2);
    step(1, 1, e1, e2, 0, Z, Z);
    chk("coinc_state2", 64'(lock_state), 64'd2);

    // Coast for five frames, re-acquire tracking, miss count restarts.
    for (int f = 0; f < 5; f++) frame(0, Z, Z, 0, Z, Z);
    chk("coast5_state", 64'(lock_state), 64'd3);
    frame(0, Z, Z, 1, tb1, tk2);
    chk("relock_state", 64'(lock_state), 64'd2);
    chk("relock_disp1", 64'(disp_eye1), 64'(tb1));
    for (int f = 0; f < 8; f++) begin
      frame(0, Z, Z, 0, Z, Z);
      chk("remiss_state", 64'(lock_state), (f < 7) ? 64'd3 : 64'd0);
    end

    // Randomized frames with occasional mid-frame resets.
    for (int f = 0; f < 150; f++) begin
      int len, pd, pt, pgood;
      len   = $urandom_range(2, 9);
      pd    = $urandom_range(0, 60);
      pt    = $urandom_range(0, 60);
      pgood = $urandom_range(50, 95);
      for (int c = 0; c < len; c++) begin
        bit dv, tv;
        dv = ($urandom_range(0, 99) < pd);
        tv = ($urandom_range(0, 99) < pt);
        step((c == len - 1), dv,
             rand_box($urandom_range(0, 99) < pgood), rand_box($urandom_range(0, 99) < pgood),
             tv,
             rand_box($urandom_range(0, 99) < pgood), rand_box($urandom_range(0, 99) < pgood));
      end
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
